// File: rtl/ram_scanner_if.sv
// ram_scanner_if: control, RAM read-port and display bundle for ram_scanner.
//   start/stop/byte_sel : requester -> scanner (levels, sampled each cycle)
//   ram_addr            : scanner -> RAM addra
//   ram_dout            : RAM douta -> scanner (1-cycle read latency)
//   word_out/valid      : captured word and its one-cycle update pulse
//   led                 : byte lane of word_out chosen by byte_sel
//   busy/done           : scan in progress / scan finished
interface ram_scanner_if #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 32
);
    logic              start;
    logic              stop;
    logic [1:0]        byte_sel;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_dout;
    logic [DATA_W-1:0] word_out;
    logic              valid;
    logic [7:0]        led;
    logic              busy;
    logic              done;

    // Scanner side.
    modport master (
        input  start, stop, byte_sel, ram_dout,
        output ram_addr, word_out, valid, led, busy, done
    );

    // Requester / RAM side.
    modport slave (
        output start, stop, byte_sel, ram_dout,
        input  ram_addr, word_out, valid, led, busy, done
    );
endinterface

// File: rtl/ram_scanner.sv
// ram_scanner: walks FIRST_ADDR..LAST_ADDR of a 1-cycle-latency block RAM,
// captures each word and holds it on word_out for DWELL cycles, optionally
// wrapping. One byte lane of the held word is shown on the LEDs.
//   clk_i : system clock, rising edge
//   rst_i : synchronous reset, active-high
//   bus   : ram_scanner_if.master (control in, RAM address out, data in,
//           word_out/valid/led/busy/done out)
module ram_scanner #(
    parameter int unsigned ADDR_W     = 6,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned DWELL      = 50000000,
    parameter int unsigned FIRST_ADDR = 0,
    parameter int unsigned LAST_ADDR  = 63,
    parameter bit          WRAP       = 1'b0
) (
    input  logic          clk_i,
    input  logic          rst_i,
    ram_scanner_if.master bus
);
    localparam int unsigned       CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [ADDR_W-1:0] FIRST    = ADDR_W'(FIRST_ADDR);
    localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(LAST_ADDR);
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(DWELL - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WAIT,
        S_HOLD,
        S_DONE
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] word_q;
    logic              valid_q;
    logic              busy_q;
    logic              done_q;
    logic [7:0]        led_c;

    // Next scan address; LAST only reaches FIRST again, never beyond.
    always_comb begin
        addr_d = (addr_q == LAST) ? FIRST : addr_q + ADDR_W'(1);
    end

    // Scan sequencer with registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            addr_q  <= FIRST;
            cnt_q   <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (bus.stop) begin
                // Abort wins over everything, including a capture this edge.
                state_q <= S_IDLE;
                cnt_q   <= '0;
                busy_q  <= 1'b0;
                done_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE, S_DONE: begin
                        if (bus.start) begin
                            addr_q  <= FIRST;
                            state_q <= S_ADDR;
                            busy_q  <= 1'b1;
                            done_q  <= 1'b0;
                        end
                    end
                    S_ADDR: begin
                        state_q <= S_WAIT;
                    end
                    S_WAIT: begin
                        word_q  <= bus.ram_dout;
                        valid_q <= 1'b1;
                        cnt_q   <= CNT_LOAD;
                        state_q <= S_HOLD;
                    end
                    S_HOLD: begin
                        if (cnt_q == '0) begin
                            if ((addr_q != LAST) || WRAP) begin
                                addr_q  <= addr_d;
                                state_q <= S_ADDR;
                            end else begin
                                state_q <= S_DONE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // LED byte lane of the held word.
    always_comb begin
        case (bus.byte_sel)
            2'd0:    led_c = word_q[7:0];
            2'd1:    led_c = word_q[15:8];
            2'd2:    led_c = word_q[23:16];
            default: led_c = word_q[31:24];
        endcase
    end

    assign bus.ram_addr = addr_q;
    assign bus.word_out = word_q;
    assign bus.valid    = valid_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.led      = led_c;
endmodule

// File: doc/ram_scanner.md
Name: ram_scanner

Overview:
- Sequential reader for the 64x32 single-port block RAM used by the memory experiment top level.
- The write side fills the RAM from switches. This block walks an address range, reads each word at the RAM's 1-cycle read latency, and holds each word on the output for a programmable dwell time.
- Selects one byte of the held word for the 8 LEDs.
- Sits beside the RAM IP. It owns the address bus while Busy is high; the top level muxes the address bus on Busy.

Parameters:
- ADDR_W, 6, RAM address width.
- DATA_W, 32, RAM data width; must be 32 (four byte lanes).
- DWELL, 50000000, number of cycles each word is held; minimum 1.
- FIRST_ADDR, 0, first address scanned.
- LAST_ADDR, 63, last address scanned; must be >= FIRST_ADDR.
- WRAP, 0, 1 = restart at FIRST_ADDR after LAST_ADDR, 0 = stop in DONE.

Ports:
- Clk  input  1  system clock, rising edge.
- Rst  input  1  synchronous reset, active-high.
- Start  input  1  level, sampled each cycle; begins a scan from IDLE or DONE.
- Stop  input  1  level; aborts the scan and returns to IDLE.
- Byte_Sel  input  2  LED byte lane: 0=[7:0], 1=[15:8], 2=[23:16], 3=[31:24].
- RAM_Addr  output  ADDR_W  registered address to the RAM addra.
- RAM_Dout  input  DATA_W  RAM douta; valid one cycle after the address is sampled.
- Word_Out  output  DATA_W  last captured word, registered.
- Valid  output  1  one-cycle pulse when Word_Out is updated.
- LED  output  8  Word_Out byte chosen by Byte_Sel; combinational mux of registered data.
- Busy  output  1  high in ADDR, WAIT and HOLD states.
- Done  output  1  high in DONE state.

Behaviour:
- One clock (Clk). Reset is synchronous and active-high (Rst); no asynchronous reset anywhere.
- Reset values: state=IDLE, RAM_Addr=FIRST_ADDR, Word_Out=0, Valid=0, Busy=0, Done=0, dwell counter=0. LED therefore reads 0.
- States: IDLE, ADDR, WAIT, HOLD, DONE.
- IDLE:
  - Start=1 and Stop=0: RAM_Addr<=FIRST_ADDR, go to ADDR.
  - Otherwise stay in IDLE.
- ADDR (1 cycle): RAM_Addr is stable and the RAM samples it at the end of this cycle. Go to WAIT.
- WAIT (1 cycle): RAM_Dout is valid. At the end of the cycle: Word_Out<=RAM_Dout, Valid<=1, counter<=DWELL-1. Go to HOLD.
- HOLD:
  - Valid is high only in the first HOLD cycle.
  - Counter decrements each cycle, so HOLD lasts exactly DWELL cycles.
  - When the counter reaches 0:
    - If RAM_Addr!=LAST_ADDR: RAM_Addr<=RAM_Addr+1, go to ADDR.
    - If RAM_Addr==LAST_ADDR and WRAP=1: RAM_Addr<=FIRST_ADDR, go to ADDR.
    - If RAM_Addr==LAST_ADDR and WRAP=0: go to DONE.
- DONE:
  - Done=1; Word_Out holds the last word.
  - Start=1 and Stop=0: RAM_Addr<=FIRST_ADDR, go to ADDR, Done cleared.
  - Stop=1: go to IDLE.
- Latency:
  - Start sampled high at edge N: ADDR in cycle N+1, WAIT in N+2, Valid high in N+3 with the new Word_Out.
  - Per word: 2+DWELL cycles.
- Stop:
  - Stop=1 in any state: next state IDLE, Valid forced 0, counter cleared.
  - Word_Out and RAM_Addr keep their values; a WAIT capture on the same edge as Stop is discarded.
  - Stop has priority over Start on the same edge.
- Start while Busy is ignored; it never restarts a scan in progress.
- Start held high continuously in IDLE/DONE starts exactly one scan per entry into those states. With WAIT-free return to IDLE only via Stop, there is no re-trigger mid-scan.
- Address arithmetic is ADDR_W-bit. Increment never passes LAST_ADDR. FIRST_ADDR==LAST_ADDR scans a single word repeatedly (WRAP=1) or once (WRAP=0).
- Rst asserted mid-scan: all registers return to reset values on that edge, regardless of Start/Stop.
- Byte_Sel changes affect LED combinationally in the same cycle; no effect on the state machine.

Test Plan:
1. Single scan: DWELL=4, FIRST=0, LAST=3, WRAP=0; RAM[0..3]=0x11223344, 0x55667788, 0x99AABBCC, 0xDDEEFF00; pulse Start one cycle.
   -> Valid pulses at cycles 3, 9, 15, 21 after Start with those words in order. Done=1 from cycle 25; Word_Out=0xDDEEFF00.
2. Byte select: after scenario 1, step Byte_Sel through 0, 1, 2, 3.
   -> LED = 0x00, 0xFF, 0xEE, 0xDD.
3. Wrap: same setup with WRAP=1.
   -> After the address-3 word, RAM_Addr returns to 0 and Valid shows 0x11223344 again 6 cycles later. Done stays 0.
4. Stop mid-scan: assert Stop during HOLD of address 1.
   -> Next cycle IDLE, Busy=0, Word_Out=0x55667788 retained, no further Valid. Start and Stop together afterwards stays IDLE.
5. Start while busy, and restart: re-pulse Start during HOLD.
   -> No change in sequence. Pulse Start in DONE -> rescan from address 0 with the first Valid 3 cycles later.
6. Reset mid-operation: assert Rst in WAIT.
   -> Next cycle all outputs 0, RAM_Addr=FIRST_ADDR, state IDLE. The captured word is discarded.
